// File: rtl/buffered_uart_tx_if.sv
// Producer-side write handshake into the buffered UART transmitter.
// A word moves on any rising edge where s_valid and s_ready are both high.
interface buffered_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/buffered_uart_tx.sv
// Buffered UART transmitter: FIFO-fed framer, tx low one clock after a push to an idle empty block; s_ready drops when the FIFO is full.
// Define UART_TX_BREAK_EN to add the break_req input for line-break generation.
module buffered_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  buffered_uart_tx_if.slave           s_if,
  input  logic [DIV_WIDTH-1:0]        baud_div,
  input  logic                        cfg_parity_en,
  input  logic                        cfg_parity_odd,
  input  logic                        cfg_two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                        break_req,
`endif
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  push, pop, brk;
  logic [DATA_WIDTH-1:0] head;

  state_t                state_q;
  logic                  tx_q, busy_q;
  logic [DIV_WIDTH-1:0]  cnt_q, div_m1_q, div_m1_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BW-1:0]         bit_q;
  logic                  par_en_q, par_bit_q, stop_more_q;
  logic                  bit_end, last_bit;

`ifdef UART_TX_BREAK_EN
  assign brk = break_req;
`else
  assign brk = 1'b0;
`endif

  assign s_if.s_ready = (count_q < CW'(FIFO_DEPTH));
  assign push         = s_if.s_valid && s_if.s_ready;
  assign head         = mem_q[rd_ptr_q];
  assign fifo_count   = count_q;
  assign tx           = tx_q;
  assign tx_busy      = busy_q;

  // Divisors below 2 collapse to 2 clocks per bit; the counter runs 0..div-1.
  assign div_m1_d = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : baud_div - DIV_WIDTH'(1);
  assign bit_end  = (cnt_q == div_m1_q);
  assign last_bit = (bit_q == BW'(DATA_WIDTH - 1));

  // Pop from idle, or on the final clock of the last stop bit so frames chain without a gap.
  assign pop = (count_q != '0) && !brk &&
               ((state_q == IDLE) || (state_q == STOP && bit_end && !stop_more_q));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_if.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      div_m1_q    <= '0;
      shift_q     <= '0;
      bit_q       <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop_more_q <= 1'b0;
    end else if (pop) begin
      state_q     <= START;
      tx_q        <= 1'b0;
      busy_q      <= 1'b1;
      cnt_q       <= '0;
      div_m1_q    <= div_m1_d;
      shift_q     <= head;
      bit_q       <= '0;
      par_en_q    <= cfg_parity_en;
      par_bit_q   <= (^head) ^ cfg_parity_odd;
      stop_more_q <= cfg_two_stop;
    end else begin
      cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          tx_q   <= !brk;
          busy_q <= brk;
        end
        START: if (bit_end) begin
          state_q <= DATA;
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
        end
        DATA: if (bit_end) begin
          if (last_bit) begin
            state_q <= par_en_q ? PARITY : STOP;
            tx_q    <= par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_q   <= bit_q + 1'b1;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        PARITY: if (bit_end) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (stop_more_q) begin
            stop_more_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            tx_q    <= !brk;
            busy_q  <= brk;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffered_uart_tx.sv
`timescale 1ns/1ps
module tb_buffered_uart_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic        break_req = 1'b0;
`endif
  logic        tx, tx_busy;
  logic [4:0]  fifo_count;

  int total = 0;
  int passed = 0;

  buffered_uart_tx_if #(.DATA_WIDTH(8)) s_if();

  buffered_uart_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_if           (s_if),
    .baud_div       (baud_div),
    .cfg_parity_en  (par_en),
    .cfg_parity_odd (par_odd),
    .cfg_two_stop   (two_stop),
`ifdef UART_TX_BREAK_EN
    .break_req      (break_req),
`endif
    .tx             (tx),
    .tx_busy        (tx_busy),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  // line holds the expected tx bits in send order, first bit leftmost.
  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] div;
    logic [3:0]  eff;
    logic        pe, po, ts, scr;
    logic [3:0]  len;
    logic [15:0] line;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic push_word(input logic [7:0] w);
    @(negedge clk);
    s_if.s_valid = 1'b1;
    s_if.s_data  = w;
    @(posedge clk);
    #1 s_if.s_valid = 1'b0;
  endtask

  task automatic check_line(input logic [31:0] line, input int len, input int eff, input string nm);
    for (int i = 0; i < len; i++) begin
      logic want;
      bit   ok;
      ok   = 1'b1;
      want = line[len-1-i];
      for (int c = 0; c < eff; c++) begin
        @(negedge clk);
        if (tx !== want || tx_busy !== 1'b1) ok = 1'b0;
      end
      total++;
      if (ok) passed++;
      else $display("FAIL %s bit%0d: tx did not hold %0b with tx_busy high for %0d clocks", nm, i, want, eff);
    end
    @(negedge clk);
    chk({nm, "_idle_tx"}, tx, 1);
    chk({nm, "_idle_busy"}, tx_busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    baud_div = v.div; par_en = v.pe; par_odd = v.po; two_stop = v.ts;
    push_word(v.data);
    @(negedge clk);
    chk({nm, "_pre_tx"}, tx, 1);
    chk({nm, "_pre_count"}, fifo_count, 1);
    @(posedge clk);
    #1;
    if (v.scr) begin
      baud_div = 16'd9; par_en = ~v.pe; par_odd = ~v.po; two_stop = ~v.ts;
    end
    check_line({16'd0, v.line}, int'(v.len), int'(v.eff), nm);
  endtask

  // Samples at mid-bit for baud_div=100, starting the poll for a start bit.
  task automatic recv(output logic [7:0] b, output bit ok);
    int n;
    n = 0; b = '0; ok = 1'b1;
    @(negedge clk);
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) ok = 1'b0;
    else begin
      repeat (50) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (100) @(negedge clk);
        b[k] = tx;
      end
      repeat (100) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;

    vecs[0] = '{8'hA5, 16'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 16'b0101001011};
    vecs[1] = '{8'h07, 16'd3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd11, 16'b01110000011};
    vecs[2] = '{8'h07, 16'd2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd11, 16'b01110000001};
    vecs[3] = '{8'h3C, 16'd4, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 4'd11, 16'b00011110011};
    vecs[4] = '{8'h81, 16'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 16'b0100000011};
    vecs[5] = '{8'h5A, 16'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 4'd12, 16'b001011010111};
    vecs[6] = '{8'hC3, 16'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 16'b0110000111};

    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", s_if.s_ready, 1);
    #20;
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 7; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Back-to-back frames: no idle clock between stop and the next start.
    @(negedge clk);
    baud_div = 16'd4; par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
    push_word(8'h00);
    push_word(8'hFF);
    check_line(32'b00000000010111111111, 20, 4, "b2b");

    // Fill: one word in flight, then 17 push attempts into the empty FIFO.
    @(negedge clk);
    baud_div = 16'd100;
    push_word(8'h10);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk($sformatf("fill_count%0d", i), fifo_count, i);
      chk($sformatf("fill_ready%0d", i), s_if.s_ready, (i < 16) ? 1 : 0);
      s_if.s_valid = 1'b1;
      s_if.s_data  = 8'h20 + 8'(i);
      @(posedge clk);
      #1 s_if.s_valid = 1'b0;
    end
    @(negedge clk);
    chk("full_count_after17", fifo_count, 16);
    for (int j = 0; j < 17; j++) begin
      recv(b, ok);
      if (!ok) begin
        total++;
        $display("FAIL full_rx%0d: no start bit within 3000 clocks, expected word %0h", j, (j == 0) ? 8'h10 : 8'h20 + 8'(j - 1));
      end else chk($sformatf("full_rx%0d", j), b, (j == 0) ? 8'h10 : 8'h20 + 8'(j - 1));
    end
    repeat (60) @(negedge clk);
    chk("full_end_tx", tx, 1);
    chk("full_end_busy", tx_busy, 0);
    chk("full_end_count", fifo_count, 0);

    // Asynchronous reset mid-DATA with three words still queued.
    @(negedge clk);
    baud_div = 16'd10;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    repeat (25) @(negedge clk);
    chk("mid_count", fifo_count, 3);
    chk("mid_busy", tx_busy, 1);
    chk("mid_tx_bit1", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", tx_busy, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_ready", s_if.s_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 5'd0) ok = 1'b0;
    end
    chk("post_rst_quiet", ok, 1);
    run_vec(vecs[0], "post_rst");

`ifdef UART_TX_BREAK_EN
    @(negedge clk);
    baud_div = 16'd4; par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
    break_req = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b0 || tx_busy !== 1'b1) ok = 1'b0;
      if (i == 10) begin
        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'h96;
      end
      if (i == 11) s_if.s_valid = 1'b0;
    end
    chk("brk_line_low", ok, 1);
    chk("brk_word_held", fifo_count, 1);
    break_req = 1'b0;
    @(posedge clk);
    #1;
    check_line(32'b0011010011, 10, 4, "brk_frame");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/buffered_uart_tx.md
BUFFERED_UART_TX -- requirements
Module: buffered_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter DIV_WIDTH, default 16, width of the runtime baud divisor.
REQ-004 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port s_valid  input  1  write request from the producer.
REQ-007 SHALL have port s_data  input  DATA_WIDTH  word to enqueue.
REQ-008 SHALL have port s_ready  output  1  FIFO can accept a word.
REQ-009 SHALL have port baud_div  input  DIV_WIDTH  clocks per bit.
REQ-010 SHALL have port cfg_parity_en  input  1  parity bit appended when high.
REQ-011 SHALL have port cfg_parity_odd  input  1  parity type: 1 is odd, 0 is even.
REQ-012 SHALL have port cfg_two_stop  input  1  two stop bits when high, one when low.
REQ-013 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-014 SHALL have port tx_busy  output  1  a frame is in progress.
REQ-015 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL enqueue s_data on an edge where s_valid and s_ready are both high; s_ready = (fifo_count < FIFO_DEPTH), combinational from count.
REQ-017 SHALL have FSM states IDLE, START, DATA, PARITY, STOP; encoding is free; any illegal state SHALL go to IDLE with tx high.
REQ-018 SHALL, in IDLE with the FIFO non-empty, on one edge: pop the head word, latch baud_div/cfg_* for the whole frame, drive tx low and enter START.
REQ-019 SHALL hold every bit for exactly max(baud_div,2) clocks; baud_div values 0 and 1 are treated as 2.
REQ-020 SHALL send the frame as: start bit (0), DATA_WIDTH data bits LSB first, a parity bit if latched parity_en, then 1 or 2 stop bits (1).
REQ-021 SHALL compute parity as the XOR of the data bits; odd type inverts it.
REQ-022 SHALL, at the last clock of the last stop bit, pop the next word and go directly to START if the FIFO is non-empty; no idle cycle occurs between frames.
REQ-023 SHALL drive tx_busy high from the pop edge until the edge that returns to IDLE.
REQ-024 SHALL NOT let a simultaneous push and pop change the count; pushing to an empty FIFO makes the word poppable on the next edge.
REQ-025 SHALL give a latency of one clock: a word pushed at edge N into an empty, idle block gives tx low from edge N+1.
REQ-026 SHALL ignore changes to baud_div/cfg_* mid-frame; they take effect at the next pop.

Reset
REQ-027 SHALL, on rst_n low, immediately set: tx=1, tx_busy=0, FSM IDLE, FIFO pointers and count 0 (s_ready=1), counters 0; a frame in progress is abandoned and the FIFO contents are discarded.
REQ-028 SHALL resume normal operation on the first edge after rst_n deasserts.

Configuration
REQ-029 SHALL gate break generation with macro UART_TX_BREAK_EN: when defined, an input port break_req (1 bit) is added.
REQ-030 SHALL, with UART_TX_BREAK_EN defined, drive tx low and tx_busy high while break_req is high in IDLE; FIFO pops are suppressed meanwhile; a break requested mid-frame starts after that frame's stop bits.
REQ-031 SHALL, without UART_TX_BREAK_EN, have no break_req port and no break logic.

Verification
REQ-032 SHALL cover: DATA_WIDTH=8, baud_div=4, no parity, 1 stop, push 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 4 clocks (40 clocks); tx_busy low afterwards.
REQ-033 SHALL cover: parity_en=1, even, push 0x07 -> parity bit 1; odd, push 0x07 -> parity bit 0; two_stop=1 -> 8 clocks high before the next start.
REQ-034 SHALL cover: 17 pushes with baud_div=100 -> s_ready low when fifo_count=16; the 17th word is not enqueued; all 16 words are sent in order.
REQ-035 SHALL cover: push 0x00 and 0xFF back-to-back -> the second start bit begins immediately after the first stop bit with no gap; tx_busy stays high throughout.
REQ-036 SHALL cover: rst_n asserted mid-DATA with 3 words queued -> tx=1, fifo_count=0 and tx_busy=0 without waiting for a clock edge.
REQ-037 SHALL cover (UART_TX_BREAK_EN defined): break_req high for 50 clocks while idle -> tx low for those clocks; a word pushed meanwhile is sent only after break_req falls.
